// File: rtl/ram_dp_clr_if.sv
// Port bundle for ram_dp_clr: clear request, two independent read/write ports, status flags.
// The master side drives requests; the slave side is the RAM.
interface ram_dp_clr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  clear;
  logic [ADDR_WIDTH-1:0] address_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic                  wren_a;
  logic [DATA_WIDTH-1:0] q_a;
  logic [ADDR_WIDTH-1:0] address_b;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  wren_b;
  logic [DATA_WIDTH-1:0] q_b;
  logic                  busy;
  logic                  collision;

  modport master (
    output clear, address_a, data_a, wren_a, address_b, data_b, wren_b,
    input  q_a, q_b, busy, collision
  );

  modport slave (
    input  clear, address_a, data_a, wren_a, address_b, data_b, wren_b,
    output q_a, q_b, busy, collision
  );
endinterface

// File: rtl/ram_dp_clr.sv
// True dual-port RAM with a full-memory clear sequence; define RAM_DP_CLR_BYPASS_EN for write-first reads.
// Latency: 1 cycle read data; a clear takes 2**ADDR_WIDTH cycles.
// Backpressure: none; busy is high while clearing and all port accesses are dropped.
module ram_dp_clr #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic         clock,
  input logic         reset,
  ram_dp_clr_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic [ADDR_WIDTH-1:0] clr_addr_d;
  logic                  clr_we;
  logic                  run;
  logic                  same_addr;
  logic                  we_a;
  logic                  we_b;
  logic                  coll_d;
  logic                  coll_q;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;
  logic [DATA_WIDTH-1:0] q_a_q;
  logic [DATA_WIDTH-1:0] q_b_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (bus.clear) begin
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
          if (&clr_addr_q) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign same_addr = (bus.address_a == bus.address_b);
  // Port A wins a same-address double write; B's write is suppressed.
  assign we_a      = run && bus.wren_a;
  assign we_b      = run && bus.wren_b && !(bus.wren_a && same_addr);
  assign coll_d    = run && bus.wren_a && bus.wren_b && same_addr;

  // Array has no reset; writes are blocked while reset is held so an aborted cycle leaves no trace.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clr_we) mem[clr_addr_q]  <= CLEAR_VALUE;
      if (we_a)   mem[bus.address_a] <= bus.data_a;
      if (we_b)   mem[bus.address_b] <= bus.data_b;
    end
  end

`ifdef RAM_DP_CLR_BYPASS_EN
  always_comb begin
    rd_a = mem[bus.address_a];
    if (we_b && same_addr) rd_a = bus.data_b;
    if (we_a)              rd_a = bus.data_a;
    rd_b = mem[bus.address_b];
    if (we_a && same_addr) rd_b = bus.data_a;
    if (we_b)              rd_b = bus.data_b;
  end
`else
  always_comb begin
    rd_a = mem[bus.address_a];
    rd_b = mem[bus.address_b];
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_a_q  <= '0;
      q_b_q  <= '0;
      coll_q <= 1'b0;
    end else begin
      q_a_q  <= run ? rd_a : '0;
      q_b_q  <= run ? rd_b : '0;
      coll_q <= coll_d;
    end
  end

  assign bus.q_a       = q_a_q;
  assign bus.q_b       = q_b_q;
  assign bus.busy      = !run;
  assign bus.collision = coll_q;
endmodule

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter CLEAR_VALUE, default 0, DATA_WIDTH-bit word written to every location during clear.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clear  input  1  synchronous request to re-clear the whole memory.
REQ-007 address_a  input  ADDR_WIDTH  port A address.
REQ-008 data_a  input  DATA_WIDTH  port A write data.
REQ-009 wren_a  input  1  port A write enable.
REQ-010 q_a  output  DATA_WIDTH  port A registered read data.
REQ-011 address_b, data_b, wren_b, q_b SHALL mirror REQ-007..010 for port B.
REQ-012 busy  output  1  high while clear sequence runs; port accesses ignored.
REQ-013 collision  output  1  one-cycle pulse: both ports wrote the same address.

Function
REQ-014 FSM SHALL have two states: CLEAR (busy=1) and RUN (busy=0).
REQ-015 In CLEAR, each rising edge SHALL write CLEAR_VALUE to mem[clr_addr] and increment clr_addr (ADDR_WIDTH bits).
REQ-016 The edge writing clr_addr = DEPTH-1 SHALL move FSM to RUN; clearing takes exactly DEPTH edges.
REQ-017 clear=1 sampled in RUN SHALL move to CLEAR with clr_addr=0; the first clear write occurs on the following edge.
REQ-018 clear=1 sampled in CLEAR SHALL restart clr_addr at 0 on that edge.
REQ-019 In CLEAR, wren_a/wren_b SHALL be ignored, and q_a/q_b SHALL register 0.
REQ-020 In RUN, q_a/q_b SHALL present mem[address] one cycle after address is sampled (latency 1).
REQ-021 In RUN, both ports SHALL write independently on the same edge when addresses differ.
REQ-022 In RUN, wren_a=wren_b=1 with address_a==address_b SHALL store data_a only and set collision=1 for exactly the next cycle.
REQ-023 collision SHALL be 0 in every other cycle, including all CLEAR cycles.
REQ-024 Read-during-write (same or opposite port, same address) SHALL return old contents unless REQ-031 applies.
REQ-025 Address arithmetic SHALL wrap modulo DEPTH; no out-of-range access exists.

Reset
REQ-026 reset=1 SHALL immediately force FSM=CLEAR, clr_addr=0, busy=1, q_a=0, q_b=0, collision=0.
REQ-027 Reset asserted mid-clear or mid-write SHALL abort the operation; clearing restarts from address 0 after release.
REQ-028 Memory array contents are not reset directly; they become CLEAR_VALUE only via the clear sequence.
REQ-029 busy SHALL deassert after the DEPTH-th rising edge following reset release; port writes are accepted from edge DEPTH+1.

Configuration
REQ-030 Macro RAM_DP_CLR_BYPASS_EN SHALL select read-during-write behaviour.
REQ-031 Defined: a RUN-state read whose address matches an accepted write on the same edge SHALL return the stored (winning) write data (write-first, across ports).
REQ-032 Undefined: behaviour SHALL be read-first per REQ-024; no forwarding logic is present.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, CLEAR_VALUE=8'hA5)
REQ-033 Release reset -> busy=1 for 16 edges, then 0; reading addresses 0..15 returns 8'hA5.
REQ-034 RUN: A writes 8'h11@3, B writes 8'h22@7 same edge -> later reads: @3=8'h11, @7=8'h22, collision stays 0.
REQ-035 RUN: A writes 8'h33@5, B writes 8'h44@5 same edge -> @5 reads 8'h33; collision=1 for one cycle.
REQ-036 @9=8'hA5; A writes 8'h5A@9 while B reads @9 -> q_b=8'hA5 (8'h5A with RAM_DP_CLR_BYPASS_EN); next read 8'h5A.
REQ-037 Assert clear, then reset at clear edge 6 -> busy held, q=0; after release, 16 more edges to RUN; all locations 8'hA5.
REQ-038 Writes during busy (wren_a=1, 8'hFF@2) -> ignored; @2 reads 8'hA5 after clear.
